// File: rtl/rca_pipe_addsub.sv
// rca_pipe_addsub: pipelined ripple-carry adder/subtractor.
// WIDTH bits are resolved CHUNK bits per stage, one register per stage, with
// the stage carry handed to the next stage. Valid/ready on both sides; the
// whole pipe advances together when the output is empty or being taken.
// Optional: define RCA_PIPE_OVF_EN to add the signed-overflow output ovf.
module rca_pipe_addsub #(
   parameter int WIDTH = 32,   // must be a multiple of CHUNK
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef RCA_PIPE_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int STAGES = WIDTH / CHUNK;

   // Single global enable: the pipe moves only when the last stage is empty
   // or its beat is being consumed. Bubbles travel like beats.
   logic advance;
   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

`ifdef RCA_PIPE_OVF_EN
   logic ovf_q;
`endif

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      // Operand bits still to be resolved at this stage's input; the low
      // CHUNK bits are consumed here, the rest are forwarded.
      localparam int IW = WIDTH - k * CHUNK;

      logic [IW-1:0]          a_in;
      logic [IW-1:0]          b_in;
      logic                   c_in;
      logic                   v_in;
      logic [(k+1)*CHUNK-1:0] s_next;
      logic [CHUNK:0]         res;

      logic                   v_q;
      logic                   c_q;
      logic [(k+1)*CHUNK-1:0] s_q;

      // Chunk adder: low CHUNK operand bits plus incoming carry.
      assign res = {1'b0, a_in[CHUNK-1:0]} + {1'b0, b_in[CHUNK-1:0]}
                 + {{CHUNK{1'b0}}, c_in};

      if (k == 0) begin : g_head
         // Subtraction is a + ~b + ~cin; b and cin are folded here so the
         // rest of the pipe only ever adds.
         assign a_in   = a;
         assign b_in   = b ^ {WIDTH{sub}};
         assign c_in   = cin ^ sub;
         assign v_in   = in_valid;
         assign s_next = res[CHUNK-1:0];
      end else begin : g_body
         assign a_in   = g_stage[k-1].g_fwd.a_q;
         assign b_in   = g_stage[k-1].g_fwd.b_q;
         assign c_in   = g_stage[k-1].c_q;
         assign v_in   = g_stage[k-1].v_q;
         assign s_next = {res[CHUNK-1:0], g_stage[k-1].s_q};
      end

      // Stage register: valid, carry and resolved low sum bits.
      // NOTE: sequential state uses non-blocking assignment so every stage
      // samples its predecessor's pre-edge value; blocking would let one beat
      // race through several stages in a single clock.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v_q <= 1'b0;
            c_q <= 1'b0;
            s_q <= '0;
         end else if (advance) begin
            v_q <= v_in;
            c_q <= res[CHUNK];
            s_q <= s_next;
         end
      end

      if (k < STAGES - 1) begin : g_fwd
         logic [IW-CHUNK-1:0] a_q;
         logic [IW-CHUNK-1:0] b_q;

         // Forward the unresolved upper operand bits to the next stage.
         // NOTE: these are plain pipeline flops, not a memory, so they take
         // the asynchronous clear too; a reset pipe holds no trace of old data.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_q <= '0;
               b_q <= '0;
            end else if (advance) begin
               a_q <= a_in[IW-1:CHUNK];
               b_q <= b_in[IW-1:CHUNK];
            end
         end
      end

`ifdef RCA_PIPE_OVF_EN
      if (k == STAGES - 1) begin : g_ovf
         // Signed overflow: carry into MSB (a^b^sum at the MSB) XOR carry out.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               ovf_q <= 1'b0;
            end else if (advance) begin
               ovf_q <= a_in[CHUNK-1] ^ b_in[CHUNK-1] ^ res[CHUNK-1] ^ res[CHUNK];
            end
         end
      end
`endif
   end

   assign out_valid = g_stage[STAGES-1].v_q;
   assign sum       = g_stage[STAGES-1].s_q;
   assign cout      = g_stage[STAGES-1].c_q;
`ifdef RCA_PIPE_OVF_EN
   assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_rca_pipe_addsub.sv
// tb_rca_pipe_addsub: scoreboard bench for rca_pipe_addsub (32/8 main
// instance plus 8/1 and 8/8 instances for the latency extremes).
module tb_rca_pipe_addsub;

   typedef struct packed {
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        cin = 1'b0;
   logic        sub = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] sum;
   logic        cout;
`ifdef RCA_PIPE_OVF_EN
   logic        ovf;
   logic        c1_ovf;
   logic        c8_ovf;
`endif

   logic        s_valid = 1'b0;
   logic [7:0]  s_a = '0;
   logic [7:0]  s_b = '0;
   logic        c1_in_ready, c1_out_valid, c1_cout;
   logic        c8_in_ready, c8_out_valid, c8_cout;
   logic [7:0]  c1_sum, c8_sum;

   int   total = 0;
   int   bad = 0;
   exp_t sb[$];
   bit   rand_mode = 1'b0;

   always #5 clk = ~clk;

   rca_pipe_addsub #(.WIDTH(32), .CHUNK(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
      .out_ready(out_ready), .sum(sum), .cout(cout)
`ifdef RCA_PIPE_OVF_EN
      , .ovf(ovf)
`endif
   );

   rca_pipe_addsub #(.WIDTH(8), .CHUNK(1)) u_c1 (
      .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_ready(c1_in_ready),
      .a(s_a), .b(s_b), .cin(1'b0), .sub(1'b0), .out_valid(c1_out_valid),
      .out_ready(1'b1), .sum(c1_sum), .cout(c1_cout)
`ifdef RCA_PIPE_OVF_EN
      , .ovf(c1_ovf)
`endif
   );

   rca_pipe_addsub #(.WIDTH(8), .CHUNK(8)) u_c8 (
      .clk(clk), .rst_n(rst_n), .in_valid(s_valid), .in_ready(c8_in_ready),
      .a(s_a), .b(s_b), .cin(1'b0), .sub(1'b0), .out_valid(c8_out_valid),
      .out_ready(1'b1), .sum(c8_sum), .cout(c8_cout)
`ifdef RCA_PIPE_OVF_EN
      , .ovf(c8_ovf)
`endif
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Reference: plain arithmetic, a-b-cin for subtract, signed range for ovf.
   function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb,
                                  input logic mc, input logic ms);
      logic [32:0] t;
      longint      sr;
      exp_t        e;
      if (ms) begin
         t = {1'b0, ma} - {1'b0, mb} - {32'b0, mc};
         e.cout = ~t[32];
         sr = longint'($signed(ma)) - longint'($signed(mb)) - longint'(mc);
      end else begin
         t = {1'b0, ma} + {1'b0, mb} + {32'b0, mc};
         e.cout = t[32];
         sr = longint'($signed(ma)) + longint'($signed(mb)) + longint'(mc);
      end
      e.sum = t[31:0];
      e.ovf = (sr > 64'sh0000_0000_7FFF_FFFF) || (sr < -64'sh0000_0000_8000_0000);
      return e;
   endfunction

   // Present one beat and hold it until accepted (bounded).
   task automatic drive(input logic [31:0] da, input logic [31:0] db,
                        input logic dc, input logic ds);
      bit acc = 1'b0;
      a = da; b = db; cin = dc; sub = ds; in_valid = 1'b1;
      for (int n = 0; n < 200 && !acc; n++) begin
         @(negedge clk);
         if (in_ready) begin
            acc = 1'b1;
            sb.push_back(model(da, db, dc, ds));
         end
         @(posedge clk); #1;
         if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
      end
      if (!acc) check("accept_timeout", 64'd0, 64'd1);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk); #1;
         if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
      end
   endtask

   // Scoreboard consumer: compare every beat that leaves the pipe.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_beat", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("sum", 64'(sum), 64'(e.sum));
            check("cout", 64'(cout), 64'(e.cout));
`ifdef RCA_PIPE_OVF_EN
            check("ovf", 64'(ovf), 64'(e.ovf));
`endif
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat1, lat8;
      logic [7:0] s1, s8;
      logic       k1, k8;

      // Reset values
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_sum", 64'(sum), 64'd0);
      check("rst_cout", 64'(cout), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
`ifdef RCA_PIPE_OVF_EN
      check("rst_ovf", 64'(ovf), 64'd0);
`endif
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Carry ripples through all four stages; latency 4 edges
      out_ready = 1'b1;
      drive(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("latency_early", 64'(out_valid), 64'd0);
      end
      @(negedge clk);
      check("latency_due", 64'(out_valid), 64'd1);
      check("ripple_sum", 64'(sum), 64'd0);
      check("ripple_cout", 64'(cout), 64'd1);
      idle(2);

      // Subtraction with borrow in/out
      drive(32'd5, 32'd7, 1'b0, 1'b1);
      drive(32'd7, 32'd5, 1'b1, 1'b1);
      idle(6);

      // Backpressure: fill the pipe with out_ready low, hold, then drain
      out_ready = 1'b0;
      drive(32'd1, 32'd1, 1'b0, 1'b0);
      drive(32'd2, 32'd2, 1'b0, 1'b0);
      drive(32'd3, 32'd3, 1'b0, 1'b0);
      drive(32'd4, 32'd4, 1'b0, 1'b0);
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall_in_ready", 64'(in_ready), 64'd0);
         check("stall_valid", 64'(out_valid), 64'd1);
         check("stall_sum_held", 64'(sum), 64'd2);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      idle(8);
      check("stall_drained", 64'(sb.size()), 64'd0);

      // Random stream with random backpressure and bubbles
      rand_mode = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 4) == 0) idle(1);
         drive($urandom(), $urandom(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      rand_mode = 1'b0;
      out_ready = 1'b1;
      idle(10);
      check("random_drained", 64'(sb.size()), 64'd0);

      // Signed overflow corners (ovf compared only when the port exists)
      drive(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
      drive(32'h8000_0000, 32'd1, 1'b0, 1'b1);
      drive(32'd3, 32'd4, 1'b0, 1'b0);
      idle(8);

      // Asynchronous reset with three beats in flight
      drive(32'd10, 32'd1, 1'b0, 1'b0);
      drive(32'd20, 32'd2, 1'b0, 1'b0);
      drive(32'd30, 32'd3, 1'b0, 1'b0);
      in_valid = 1'b0;
      @(posedge clk); #2;
      check("pre_reset_valid", 64'(out_valid), 64'd1);
      rst_n = 1'b0;
      #1;
      check("async_rst_valid", 64'(out_valid), 64'd0);
      check("async_rst_sum", 64'(sum), 64'd0);
      check("async_rst_in_ready", 64'(in_ready), 64'd1);
      sb.delete();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("no_stale_beat", 64'(out_valid), 64'd0);
      end
      check("post_rst_in_ready", 64'(in_ready), 64'd1);

      // Latency extremes: 8/1 (eight stages) and 8/8 (one stage)
      @(posedge clk); #1;
      s_a = 8'hFF; s_b = 8'h01; s_valid = 1'b1;
      @(negedge clk);
      check("c1_in_ready", 64'(c1_in_ready), 64'd1);
      check("c8_in_ready", 64'(c8_in_ready), 64'd1);
      @(posedge clk); #1;
      s_valid = 1'b0;
      lat1 = 0; lat8 = 0; s1 = 8'hAA; s8 = 8'hAA; k1 = 1'b0; k8 = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (lat8 == 0 && c1_out_valid) begin
            lat8 = k; s1 = c1_sum; k1 = c1_cout;
         end
         if (lat1 == 0 && c8_out_valid) begin
            lat1 = k; s8 = c8_sum; k8 = c8_cout;
         end
      end
      check("chunk1_latency", 64'(lat8), 64'd8);
      check("chunk1_sum", 64'(s1), 64'd0);
      check("chunk1_cout", 64'(k1), 64'd1);
      check("chunk8_latency", 64'(lat1), 64'd1);
      check("chunk8_sum", 64'(s8), 64'd0);
      check("chunk8_cout", 64'(k8), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
